// File: rtl/set_associative_fifo_pkg.sv
// Shared geometry and address-field helpers for the 4-way write-through cache.
package set_associative_fifo_pkg;

   localparam int NUM_SETS = 256;
   localparam int WAYS     = 4;
   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int OFFSET_W = 2;
   localparam int INDEX_W  = $clog2(NUM_SETS);
   localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
   localparam int PTR_W    = $clog2(WAYS);

   typedef logic [TAG_W-1:0]   tag_t;
   typedef logic [INDEX_W-1:0] index_t;
   typedef logic [DATA_W-1:0]  data_t;
   typedef logic [PTR_W-1:0]   ptr_t;

   function automatic tag_t get_tag(input logic [ADDR_W-1:0] addr);
      return tag_t'(addr >> (ADDR_W - TAG_W));
   endfunction

   function automatic index_t get_index(input logic [ADDR_W-1:0] addr);
      return index_t'(addr >> OFFSET_W);
   endfunction

endpackage

// File: rtl/set_associative_fifo_way.sv
// One cache way: per-set valid/tag/data storage with a combinational tag compare.
module set_assoc_fifo_way
   import set_associative_fifo_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  index_t index,
   input  tag_t   tag,
   input  logic   wr_en,
   input  data_t  wr_data,
   output logic   match,
   output data_t  rd_data
);

   logic [NUM_SETS-1:0] valid;
   tag_t                tag_mem  [NUM_SETS];
   data_t               data_mem [NUM_SETS];

   // Only valid bits need clearing; stale tag/data are invisible once invalid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) valid <= '0;
      else if (wr_en) valid[index] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[index]  <= tag;
         data_mem[index] <= wr_data;
      end
   end

   assign match   = valid[index] && (tag_mem[index] == tag);
   assign rd_data = data_mem[index];

endmodule

// File: rtl/set_associative_fifo.sv
// 4-way set-associative write-through/write-allocate cache with per-set FIFO victim pointer.
module set_associative_fifo
   import set_associative_fifo_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_write_data,
   output logic [DATA_W-1:0] cpu_read_data,
   output logic              hit1,
   output logic              hit2,
   output logic              hit3,
   output logic              hit4,
   output logic              HIT,
   output logic              MISS,
   output logic              mem_req,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic [PTR_W-1:0]  fifo_counter_out,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);

   index_t          index;
   tag_t            tag;
   logic [WAYS-1:0] match;
   logic [WAYS-1:0] wr_en;
   data_t           rd_data [WAYS];
   data_t           hit_data;
   data_t           line_data;
   ptr_t            fifo_ptr [NUM_SETS];
   ptr_t            victim;
   ptr_t            victim_next;
   logic            hit;

   assign index       = get_index(cpu_addr);
   assign tag         = get_tag(cpu_addr);
   assign victim      = fifo_ptr[index];
   assign victim_next = victim + ptr_t'(1);
   assign hit         = |match;
   assign line_data   = cpu_write ? cpu_write_data : mem_read_data;

   always_comb begin
      hit_data = '0;
      for (int w = 0; w < WAYS; w++)
         if (match[w]) hit_data = hit_data | rd_data[w];
   end

   // Hits only write the line on stores; misses always fill the FIFO victim.
   always_comb begin
      wr_en = '0;
      for (int w = 0; w < WAYS; w++)
         wr_en[w] = cpu_req && (hit ? (cpu_write && match[w]) : (victim == ptr_t'(w)));
   end

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      set_assoc_fifo_way u_way (
         .clk     (clk),
         .reset   (reset),
         .index   (index),
         .tag     (tag),
         .wr_en   (wr_en[w]),
         .wr_data (line_data),
         .match   (match[w]),
         .rd_data (rd_data[w])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu_read_data    <= '0;
         {hit4, hit3, hit2, hit1} <= '0;
         HIT              <= 1'b0;
         MISS             <= 1'b0;
         mem_req          <= 1'b0;
         mem_write        <= 1'b0;
         mem_addr         <= '0;
         mem_write_data   <= '0;
         fifo_counter_out <= '0;
         hit_count        <= '0;
         miss_count       <= '0;
         for (int s = 0; s < NUM_SETS; s++) fifo_ptr[s] <= '0;
      end else if (cpu_req) begin
         {hit4, hit3, hit2, hit1} <= match;
         HIT       <= hit;
         MISS      <= !hit;
         mem_req   <= cpu_write || !hit;
         mem_write <= cpu_write;
         mem_addr  <= cpu_addr;
         if (cpu_write) mem_write_data <= cpu_write_data;
         else           cpu_read_data  <= hit ? hit_data : mem_read_data;
         if (hit) begin
            hit_count        <= hit_count + 32'd1;
            fifo_counter_out <= victim;
         end else begin
            miss_count       <= miss_count + 32'd1;
            fifo_ptr[index]  <= victim_next;
            fifo_counter_out <= victim_next;
         end
      end else begin
         {hit4, hit3, hit2, hit1} <= '0;
         HIT       <= 1'b0;
         MISS      <= 1'b0;
         mem_req   <= 1'b0;
         mem_write <= 1'b0;
      end
   end

endmodule

// File: tb/tb_set_associative_fifo.sv
// Randomized and directed bench for set_associative_fifo against a plain-array cache model.
module tb_set_associative_fifo;
   import set_associative_fifo_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_write;
   logic [31:0] cpu_addr, cpu_write_data, cpu_read_data;
   logic        hit1, hit2, hit3, hit4, HIT, MISS, mem_req, mem_write;
   logic [31:0] mem_addr, mem_write_data, mem_read_data;
   logic [1:0]  fifo_counter_out;
   logic [31:0] hit_count, miss_count;

   set_associative_fifo dut (
      .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_write(cpu_write),
      .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data),
      .hit1(hit1), .hit2(hit2), .hit3(hit3), .hit4(hit4), .HIT(HIT), .MISS(MISS),
      .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
      .fifo_counter_out(fifo_counter_out), .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference cache: whole-line model indexed by way and set.
   bit          m_valid [4][256];
   logic [21:0] m_tag   [4][256];
   logic [31:0] m_data  [4][256];
   int          m_ptr   [256];
   logic [31:0] e_rd, e_maddr, e_mwd, e_hits, e_miss;
   logic [1:0]  e_fifo;

   task automatic model_reset();
      for (int w = 0; w < 4; w++)
         for (int s = 0; s < 256; s++) m_valid[w][s] = 0;
      for (int s = 0; s < 256; s++) m_ptr[s] = 0;
      e_rd = 0; e_maddr = 0; e_mwd = 0; e_hits = 0; e_miss = 0; e_fifo = 0;
   endtask

   task automatic check_state(input string pfx);
      check({pfx, ".rdata"}, cpu_read_data, e_rd);
      check({pfx, ".maddr"}, mem_addr, e_maddr);
      check({pfx, ".mwdata"}, mem_write_data, e_mwd);
      check({pfx, ".fifo"}, 32'(fifo_counter_out), 32'(e_fifo));
      check({pfx, ".hits"}, hit_count, e_hits);
      check({pfx, ".misses"}, miss_count, e_miss);
   endtask

   task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] mdata);
      int          idx;
      int          way;
      logic [21:0] t;
      logic [3:0]  eh;
      bit          hit;
      idx = int'(addr / 4) % 256;
      t   = 22'(addr / 1024);
      way = -1;
      eh  = '0;
      for (int w = 0; w < 4; w++)
         if (m_valid[w][idx] && m_tag[w][idx] == t) way = w;
      hit = (way >= 0);
      if (hit) begin
         eh[way] = 1'b1;
         e_hits++;
      end else begin
         way = m_ptr[idx];
         m_ptr[idx] = (m_ptr[idx] + 1) % 4;
         m_valid[way][idx] = 1;
         m_tag[way][idx] = t;
         e_miss++;
      end
      if (wr) m_data[way][idx] = wdata;
      else if (!hit) m_data[way][idx] = mdata;
      if (!wr) e_rd = m_data[way][idx];
      else e_mwd = wdata;
      e_maddr = addr;
      e_fifo  = 2'(m_ptr[idx]);

      @(negedge clk);
      cpu_req = 1; cpu_write = wr; cpu_addr = addr;
      cpu_write_data = wdata; mem_read_data = mdata;
      @(posedge clk); #1;
      check("flags", {24'd0, hit4, hit3, hit2, hit1, HIT, MISS, mem_req, mem_write},
            {24'd0, eh, hit, !hit, wr || !hit, wr});
      check_state("acc");
   endtask

   task automatic idle();
      @(negedge clk);
      cpu_req = 0; cpu_write = 1'($urandom); cpu_addr = $urandom;
      cpu_write_data = $urandom; mem_read_data = $urandom;
      @(posedge clk); #1;
      check("idle_flags", {24'd0, hit4, hit3, hit2, hit1, HIT, MISS, mem_req, mem_write}, 32'd0);
      check_state("idle");
   endtask

   initial begin
      reset = 0; cpu_req = 0; cpu_write = 0; cpu_addr = 0;
      cpu_write_data = 0; mem_read_data = 0;
      model_reset();
      #12;
      check("reset_rdata", cpu_read_data, 32'd0);
      check("reset_counts", hit_count | miss_count, 32'd0);
      @(negedge clk); reset = 1;

      // Fill one set, then hit every way.
      for (int i = 0; i < 4; i++) begin
         access(0, 32'h004 + 32'(i) * 32'h400, 0, 32'hC001C001 * 32'(i + 1));
         check("fill_fifo", 32'(fifo_counter_out), 32'((i + 1) % 4));
      end
      check("fill_misses", miss_count, 32'd4);
      for (int i = 0; i < 4; i++) begin
         access(0, 32'h004 + 32'(i) * 32'h400, 0, 32'hDEADBEEF);
         check("rehit_data", cpu_read_data, 32'hC001C001 * 32'(i + 1));
      end
      check("rehit_hits", hit_count, 32'd4);

      // FIFO replacement order.
      access(0, 32'h1004, 0, 32'h00000001);
      access(0, 32'h0004, 0, 32'h00000004);
      check("evict_fifo", 32'(fifo_counter_out), 32'd2);

      access(1, 32'h804, 32'h33333333, 32'h0);
      check("wr_hit3", 32'(hit3), 32'd1);
      access(0, 32'h804, 0, 32'h0);
      check("wr_then_rd", cpu_read_data, 32'h33333333);

      access(1, 32'h000, 32'hAAAAAAAA, 32'h0);
      access(0, 32'h000, 0, 32'h0);
      check("alloc_rd", cpu_read_data, 32'hAAAAAAAA);
      check("final_hits", hit_count, 32'd7);
      check("final_misses", miss_count, 32'd7);
      idle();

      // Reset asserted while an access is pending.
      @(negedge clk);
      cpu_req = 1; cpu_write = 0; cpu_addr = 32'h804; mem_read_data = 32'h5;
      #2 reset = 0;
      #1;
      check("rst_async_counts", hit_count | miss_count, 32'd0);
      @(posedge clk); #1;
      check("rst_hold_flags", {28'd0, HIT, MISS, mem_req, mem_write}, 32'd0);
      check("rst_hold_rdata", cpu_read_data, 32'd0);
      @(negedge clk); reset = 1; cpu_req = 0;
      model_reset();
      access(0, 32'h804, 0, 32'h12345678);
      check("post_rst_miss", 32'(MISS), 32'd1);

      // Random traffic over a small footprint so sets fill and evict often.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] a;
         a = {22'($urandom_range(0, 5)), 8'($urandom_range(0, 3)), 2'($urandom)};
         if ($urandom_range(0, 7) == 0) idle();
         else access(1'($urandom), a, $urandom, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
